aes_light_encrypt: RTL and testbench
====================================

// Module: aes_light_encrypt
// PURPOSE
//   Byte-wide AES-like encryptor; the transmit-side counterpart of the BNN accelerator's light decryptor.
//   Takes one plaintext byte and a 1-byte key on a start pulse. Runs ROUNDS sequential rounds (SubBytes,
//   ShiftRows, AddRoundKey), one per clock. Presents the ciphertext byte with a done flag. Used to
//   pre-encrypt weights/activations and to generate reference ciphertext for the decrypt path.
// PARAMETERS
//   ROUNDS   2   number of encryption rounds; legal 1..4 (elaboration error otherwise)
// PORTS
//   clk         in   1  single clock, all state on rising edge
//   rst_n       in   1  asynchronous, active-low reset
//   start       in   1  trigger; sampled only in IDLE
//   plain_in    in   8  plaintext byte, sampled with start
//   key         in   8  symmetric key byte, sampled with start
//   cipher_out  out  8  ciphertext byte, valid while done=1
//   done        out  1  high from result cycle until start observed low
//   busy        out  1  high while rounds are in progress (ROUND state)
// BEHAVIOUR
//   Reset (rst_n=0, any time, incl. mid-round): state=IDLE; cipher_out, done, busy, working byte,
//     key reg and round counter all 0. No partial result survives.
//   Algorithm (all 8-bit, XOR/permute only, no carries):
//     RCON[1..4] = 8'h55, 8'hAA, 8'h33, 8'hCC;  rk_r = key ^ RCON[r]
//     SBOX (4-bit, applied to each nibble independently, bijective):
//       0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
//     ROTL2(x) = {x[5:0], x[7:6]}
//     s = plain_in ^ key;  for r=1..ROUNDS: s = ROTL2(SBOX(s)) ^ rk_r;  cipher_out = s
//   FSM:
//     IDLE : start=1 -> s<=plain_in^key, key_q<=key, rnd<=1, busy<=1, done<=0, go ROUND.
//            start=0 -> stay IDLE, done=0.
//     ROUND: s<=round(s,key_q^RCON[rnd]), rnd<=rnd+1.
//            On rnd==ROUNDS: cipher_out<=round result (same edge), done<=1, busy<=0, go DONE.
//     DONE : hold cipher_out, done=1. start=0 -> done<=0, go IDLE. start=1 -> stay DONE (no retrigger).
//   Latency: start sampled at edge E0; done and cipher_out valid after edge E(ROUNDS).
//     ROUNDS=2 gives done 2 cycles after the start edge.
//   Min initiation interval ROUNDS+2 cycles (DONE->IDLE needs one start=0 cycle).
//   start, plain_in and key are ignored in ROUND and DONE; changing them mid-operation has no effect.
//   cipher_out keeps its last value in IDLE; it is meaningful only while done=1.
//   busy and done are never high together. rnd is 3 bits and never exceeds ROUNDS.
// STRUCTURE
//   aes_light_pkg: state_t enum (IDLE, ROUND, DONE; 2 bits), RCON table, SBOX nibble table,
//     functions sbox8() and rotl2(). Shared with the decryptor, which also gets the inverse S-box there.
//   Sub-module aes_light_round: combinational, (s[7:0], rk[7:0]) -> ROTL2(SBOX(s)) ^ rk.
//     Instantiated once; the top holds only the FSM, registers and round-key select.
// TESTING
//   1 ROUNDS=2, plain=8'h12 key=8'h34, 1-cycle start -> cipher_out=8'h93, done at 2nd edge after start edge.
//   2 ROUNDS=2, plain=8'hFF key=8'h00 -> cipher_out=8'h77.
//     plain=8'h00 key=8'h00 -> cipher_out=8'h00.
//   3 start held high for 10 cycles -> exactly one encryption; done stays 1 until start drops,
//     then 0 one cycle later; state back in IDLE.
//   4 rst_n pulsed low during ROUND -> all outputs 0 immediately (async).
//     Next start with plain=8'h12 key=8'h34 still yields 8'h93.
//   5 plain_in/key toggled randomly during ROUND/DONE -> result equals encryption of the values
//     sampled at the start edge.
//   6 Round-trip: 256 plaintexts x 4 keys through encryptor then the pkg inverse model -> plaintext
//     recovered. Distinct plaintexts give distinct ciphertexts per key (bijectivity).

Source files
------------

// File: rtl/aes_light_pkg.sv
// Shared definitions for the light AES-like encrypt/decrypt pair: FSM states,
// round constants, the 4-bit S-box, its inverse and the byte rotations.
package aes_light_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Round constants 1..4 packed LSB-first: RCON[1]=55, [2]=AA, [3]=33, [4]=CC.
   localparam logic [31:0] RCON_TABLE = 32'hCC33_AA55;

   // Nibble S-box packed LSB-first (entry i at bits [4*i +: 4]) and its inverse.
   localparam logic [63:0] SBOX_TABLE     = 64'h2174_8FE3_DA09_B65C;
   localparam logic [63:0] INV_SBOX_TABLE = 64'hA970_364B_D21C_8FE5;

   function automatic logic [7:0] rcon(input logic [2:0] rnd);
      if (rnd == 3'd0 || rnd > 3'd4) return 8'h00;
      return RCON_TABLE[8*(int'(rnd)-1) +: 8];
   endfunction

   function automatic logic [3:0] sbox4(input logic [3:0] n);
      return SBOX_TABLE[4*int'(n) +: 4];
   endfunction

   function automatic logic [3:0] inv_sbox4(input logic [3:0] n);
      return INV_SBOX_TABLE[4*int'(n) +: 4];
   endfunction

   function automatic logic [7:0] sbox8(input logic [7:0] x);
      return {sbox4(x[7:4]), sbox4(x[3:0])};
   endfunction

   function automatic logic [7:0] inv_sbox8(input logic [7:0] x);
      return {inv_sbox4(x[7:4]), inv_sbox4(x[3:0])};
   endfunction

   function automatic logic [7:0] rotl2(input logic [7:0] x);
      return {x[5:0], x[7:6]};
   endfunction

   function automatic logic [7:0] rotr2(input logic [7:0] x);
      return {x[1:0], x[7:2]};
   endfunction

endpackage

// File: rtl/aes_light_round.sv
// One combinational encryption round: SubBytes, ShiftRows (rotate by 2), AddRoundKey.
module aes_light_round
   import aes_light_pkg::*;
(
   input  logic [7:0] s,
   input  logic [7:0] rk,
   output logic [7:0] s_next
);

   assign s_next = rotl2(sbox8(s)) ^ rk;

endmodule

// File: rtl/aes_light_encrypt.sv
// Byte-wide iterative encryptor: one round per clock, result presented with done
// until start is seen low, so a held start never retriggers.
module aes_light_encrypt
   import aes_light_pkg::*;
#(
   parameter int ROUNDS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] plain_in,
   input  logic [7:0] key,
   output logic [7:0] cipher_out,
   output logic       done,
   output logic       busy
);

   generate
      if (ROUNDS < 1 || ROUNDS > 4) begin : g_bad_rounds
         $error("aes_light_encrypt: ROUNDS must be in 1..4");
      end
   endgenerate

   localparam logic [2:0] LAST_RND = 3'(ROUNDS);

   state_t     state;
   logic [7:0] s_q;
   logic [7:0] key_q;
   logic [2:0] rnd;
   logic [7:0] round_key;
   logic [7:0] round_out;

   assign round_key = key_q ^ rcon(rnd);

   aes_light_round u_round (
      .s      (s_q),
      .rk     (round_key),
      .s_next (round_out)
   );

   // NOTE: every register here is updated with <= so all reads see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         s_q        <= '0;
         key_q      <= '0;
         rnd        <= '0;
         cipher_out <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  s_q   <= plain_in ^ key;
                  key_q <= key;
                  rnd   <= 3'd1;
                  busy  <= 1'b1;
                  state <= ROUND;
               end
            end
            ROUND: begin
               s_q <= round_out;
               if (rnd == LAST_RND) begin
                  // Counter parks at 0 so it never exceeds ROUNDS.
                  cipher_out <= round_out;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  rnd        <= '0;
                  state      <= DONE;
               end else begin
                  rnd <= rnd + 3'd1;
               end
            end
            DONE: begin
               if (!start) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_light_encrypt.sv
// Randomised self-checking bench: encryptions compared against an arithmetic
// reference model, plus round-trip and bijectivity through the package inverse.
module tb_aes_light_encrypt;
   import aes_light_pkg::*;

   localparam int R = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] plain_in;
   logic [7:0] key;
   logic [7:0] cipher_out;
   logic       done;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;
   int excl_viol = 0;

   aes_light_encrypt #(.ROUNDS(R)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .plain_in   (plain_in),
      .key        (key),
      .cipher_out (cipher_out),
      .done       (done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (busy && done) excl_viol++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model straight from the algorithm description.
   logic [3:0] sb_ref [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
   logic [7:0] rc_ref [4]  = '{8'h55, 8'hAA, 8'h33, 8'hCC};

   function automatic logic [7:0] ref_enc(input logic [7:0] p, input logic [7:0] k);
      logic [7:0] s, t;
      s = p ^ k;
      for (int r = 0; r < R; r++) begin
         t = {sb_ref[s[7:4]], sb_ref[s[3:0]]};
         t = 8'(({8'h00, t} << 2) | ({8'h00, t} >> 6));
         s = t ^ k ^ rc_ref[r];
      end
      return s;
   endfunction

   function automatic logic [7:0] inv_enc(input logic [7:0] c, input logic [7:0] k);
      logic [7:0] s;
      s = c;
      for (int r = R; r >= 1; r--) begin
         s = s ^ k ^ rcon(3'(r));
         s = inv_sbox8(rotr2(s));
      end
      return s ^ k;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: start pulse (or held), wait for done, drop start.
   task automatic run_enc(input logic [7:0] p, input logic [7:0] k,
                          input bit toggle, output logic [7:0] c);
      int cyc;
      start    = 1'b1;
      plain_in = p;
      key      = k;
      tick();
      check("busy_after_start", busy, 1);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 20) begin
         if (toggle) begin
            plain_in = 8'($urandom);
            key      = 8'($urandom);
            start    = 1'($urandom);
         end
         tick();
         cyc++;
      end
      check("latency", cyc, R);
      c = cipher_out;
      start = 1'b0;
      tick();
      check("done_drop", done, 0);
   endtask

   initial begin
      logic [7:0] c;
      int         busy_cnt, done_cnt, distinct;
      bit         seen [256];
      logic [7:0] keys [4];

      rst_n = 1'b0; start = 1'b0; plain_in = '0; key = '0;
      repeat (2) tick();
      check("rst_cipher", cipher_out, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();

      // Known vectors.
      run_enc(8'h12, 8'h34, 1'b0, c);  check("vec_12_34", c, 8'h93);
      run_enc(8'hFF, 8'h00, 1'b0, c);  check("vec_ff_00", c, 8'h77);
      run_enc(8'h00, 8'h00, 1'b0, c);  check("vec_00_00", c, 8'h00);

      // Start held high: one encryption only, done held until start drops.
      start = 1'b1; plain_in = 8'hA5; key = 8'h3C;
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
      check("held_busy_cycles", busy_cnt, R);
      check("held_done_cycles", done_cnt, 10 - R);
      check("held_cipher", cipher_out, ref_enc(8'hA5, 8'h3C));
      start = 1'b0;
      tick();
      check("held_done_drop", done, 0);
      check("idle_keeps_cipher", cipher_out, ref_enc(8'hA5, 8'h3C));
      run_enc(8'h5A, 8'hC3, 1'b0, c);  check("after_hold", c, ref_enc(8'h5A, 8'hC3));

      // Asynchronous reset in the middle of a round.
      start = 1'b1; plain_in = 8'h77; key = 8'h11;
      tick();
      start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_cipher", cipher_out, 0);
      #2 rst_n = 1'b1;
      tick();
      check("midrst_stays_idle", busy, 0);
      run_enc(8'h12, 8'h34, 1'b0, c);  check("post_rst_vec", c, 8'h93);

      // Inputs toggled while the operation is in flight.
      for (int i = 0; i < 20; i++) begin
         logic [7:0] p, k;
         p = 8'($urandom);
         k = 8'($urandom);
         run_enc(p, k, 1'b1, c);
         check("toggle_model", c, ref_enc(p, k));
      end

      // Round-trip and bijectivity over all plaintexts for four keys.
      keys[0] = 8'h00; keys[1] = 8'hFF; keys[2] = 8'h34; keys[3] = 8'($urandom);
      for (int ki = 0; ki < 4; ki++) begin
         for (int j = 0; j < 256; j++) seen[j] = 1'b0;
         for (int p = 0; p < 256; p++) begin
            run_enc(8'(p), keys[ki], 1'b0, c);
            check("model", c, ref_enc(8'(p), keys[ki]));
            check("roundtrip", inv_enc(c, keys[ki]), p);
            seen[c] = 1'b1;
         end
         distinct = 0;
         for (int j = 0; j < 256; j++) if (seen[j]) distinct++;
         check("bijective", distinct, 256);
      end

      check("busy_done_exclusive", excl_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
